// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard unit.
// Select codes drive the 3:1 operand muxes in front of the ALU.
package fwd_hazard_unit_pkg;
    localparam int NB_REG  = 5;
    localparam int NB_SEL  = 2;
    localparam int NUM_OPS = 2;   // operand A (rs), operand B (rt)

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;
endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Per-operand forwarding compare: picks the newest in-flight writer of src.
// Evaluated while the consumer is still in ID, so "EX now" becomes EX/MEM next cycle.
module fwd_select
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NB_REG = fwd_hazard_unit_pkg::NB_REG,
    parameter int NB_SEL = fwd_hazard_unit_pkg::NB_SEL
) (
    input  logic [NB_REG-1:0] src,
    input  logic              uses,
    input  logic [NB_REG-1:0] ex_dest,
    input  logic              ex_wr,
    input  logic [NB_REG-1:0] mem_dest,
    input  logic              mem_wr,
    output logic [NB_SEL-1:0] sel
);
    always_comb begin
        sel = NB_SEL'(FWD_RF);
        if (uses && src != '0) begin
            if (ex_wr && ex_dest == src)
                sel = NB_SEL'(FWD_MEM);
            else if (mem_wr && mem_dest == src)
                sel = NB_SEL'(FWD_WB);
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall control for the 5-stage pipeline.
// Tracks writer destinations through MEM/WB; selects are registered into EX.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NB_REG = fwd_hazard_unit_pkg::NB_REG,
    parameter int NB_SEL = fwd_hazard_unit_pkg::NB_SEL,
    parameter int NB_CNT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_id_valid,
    input  logic [NB_REG-1:0] i_id_rs,
    input  logic [NB_REG-1:0] i_id_rt,
    input  logic              i_id_uses_rs,
    input  logic              i_id_uses_rt,
    input  logic [NB_REG-1:0] i_ex_write_reg,
    input  logic              i_ex_reg_write,
    input  logic              i_ex_mem_read,
    input  logic              i_flush,
    output logic [NB_SEL-1:0] o_fwd_a,
    output logic [NB_SEL-1:0] o_fwd_b,
    output logic              o_stall,
    output logic [NB_CNT-1:0] o_stall_count
);
    logic [NB_REG-1:0] mem_dest, wb_dest;
    logic              mem_wr, wb_wr;
    logic              load_use, advance;

    logic [NUM_OPS-1:0][NB_REG-1:0] op_src;
    logic [NUM_OPS-1:0]             op_uses;
    logic [NUM_OPS-1:0][NB_SEL-1:0] op_sel;

    assign op_src  = {i_id_rt, i_id_rs};
    assign op_uses = {i_id_uses_rt, i_id_uses_rs};

    generate
        for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
            fwd_select #(.NB_REG(NB_REG), .NB_SEL(NB_SEL)) u_sel (
                .src      (op_src[g]),
                .uses     (op_uses[g]),
                .ex_dest  (i_ex_write_reg),
                .ex_wr    (i_ex_reg_write),
                .mem_dest (mem_dest),
                .mem_wr   (mem_wr),
                .sel      (op_sel[g])
            );
        end
    endgenerate

    always_comb begin
        load_use = (i_id_uses_rs && i_id_rs == i_ex_write_reg) ||
                   (i_id_uses_rt && i_id_rt == i_ex_write_reg);
        // A killed ID instruction cannot consume the load, so flush overrides
        o_stall  = !i_reset && !i_flush && i_id_valid && i_ex_mem_read &&
                   i_ex_reg_write && (i_ex_write_reg != '0) && load_use;
        advance  = i_id_valid && !o_stall && !i_flush;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mem_dest      <= '0;
            mem_wr        <= 1'b0;
            wb_dest       <= '0;
            wb_wr         <= 1'b0;
            o_fwd_a       <= '0;
            o_fwd_b       <= '0;
            o_stall_count <= '0;
        end else begin
            // EX always completes; bubbles arrive from upstream with reg_write=0
            mem_dest <= i_ex_write_reg;
            mem_wr   <= i_ex_reg_write && (i_ex_write_reg != '0);
            wb_dest  <= mem_dest;
            wb_wr    <= mem_wr;
            o_fwd_a  <= advance ? op_sel[0] : '0;
            o_fwd_b  <= advance ? op_sel[1] : '0;
            if (o_stall && o_stall_count != '1)
                o_stall_count <= o_stall_count + 1'b1;
        end
    end

    // WB needs no forwarding path (write-before-read RF); r0 never tracked as a writer
    always @(posedge i_clk) begin
        if (!i_reset)
            assert (!wb_wr || wb_dest != '0);
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized bench for fwd_hazard_unit against a queue-based in-flight writer model.
// Narrow counter width so saturation is reached in a short run.
module tb_fwd_hazard_unit;
    localparam int NB_REG = 5;
    localparam int NB_SEL = 2;
    localparam int NB_CNT = 4;
    localparam int CMAX   = (1 << NB_CNT) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, uses_rs, uses_rt, ex_wr, ex_mr, flush;
    logic [NB_REG-1:0] rs, rt, ex_dest;
    logic [NB_SEL-1:0] fwd_a, fwd_b;
    logic              stall;
    logic [NB_CNT-1:0] stall_count;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NB_REG(NB_REG), .NB_SEL(NB_SEL), .NB_CNT(NB_CNT)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_id_valid     (id_valid),
        .i_id_rs        (rs),
        .i_id_rt        (rt),
        .i_id_uses_rs   (uses_rs),
        .i_id_uses_rt   (uses_rt),
        .i_ex_write_reg (ex_dest),
        .i_ex_reg_write (ex_wr),
        .i_ex_mem_read  (ex_mr),
        .i_flush        (flush),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b),
        .o_stall        (stall),
        .o_stall_count  (stall_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: destinations of writers older than the EX instruction, newest first (0 = none)
    int inflight[$];
    int m_fwd_a, m_fwd_b, m_cnt;

    function automatic int sel_for(input int s, input bit used, input int cur);
        int cand[2];
        if (!used || s == 0) return 0;
        cand[0] = cur;
        cand[1] = (inflight.size() > 0) ? inflight[0] : 0;
        for (int i = 0; i < 2; i++)
            if (cand[i] == s) return i + 1;   // 1 = EX/MEM, 2 = MEM/WB
        return 0;
    endfunction

    initial begin
        int  cur;
        bit  exp_stall, adv;

        rst = 1'b1; id_valid = 0; uses_rs = 0; uses_rt = 0; ex_wr = 0; ex_mr = 0;
        flush = 0; rs = '0; rt = '0; ex_dest = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_fwd_a", 32'(fwd_a), 0);
        chk("reset_fwd_b", 32'(fwd_b), 0);
        chk("reset_cnt",   32'(stall_count), 0);
        chk("reset_stall", 32'(stall), 0);
        m_fwd_a = 0; m_fwd_b = 0; m_cnt = 0;

        for (int cyc = 0; cyc < 900; cyc++) begin
            if (cyc > 0) @(negedge clk);
            // No resets early so the counter can reach saturation
            rst      = (cyc >= 450) && ($urandom_range(0, 39) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            id_valid = ($urandom_range(0, 7) != 0);
            rs       = NB_REG'($urandom_range(0, 3));
            rt       = NB_REG'($urandom_range(0, 3));
            uses_rs  = ($urandom_range(0, 3) != 0);
            uses_rt  = ($urandom_range(0, 1) != 0);
            ex_dest  = NB_REG'($urandom_range(0, 3));
            ex_wr    = ($urandom_range(0, 3) != 0);
            ex_mr    = ($urandom_range(0, 1) != 0);
            #1;

            cur = ex_wr ? int'(ex_dest) : 0;
            exp_stall = !rst && !flush && id_valid && ex_mr && cur != 0 &&
                        ((uses_rs && int'(rs) == cur) || (uses_rt && int'(rt) == cur));

            chk("stall", 32'(stall), 32'(exp_stall));
            chk("fwd_a", 32'(fwd_a), 32'(m_fwd_a));
            chk("fwd_b", 32'(fwd_b), 32'(m_fwd_b));
            chk("count", 32'(stall_count), 32'(m_cnt));

            if (rst) begin
                m_fwd_a = 0; m_fwd_b = 0; m_cnt = 0;
                inflight.delete();
            end else begin
                adv     = id_valid && !exp_stall && !flush;
                m_fwd_a = adv ? sel_for(int'(rs), uses_rs, cur) : 0;
                m_fwd_b = adv ? sel_for(int'(rt), uses_rt, cur) : 0;
                if (exp_stall && m_cnt < CMAX) m_cnt++;
                inflight.push_front(cur);
                if (inflight.size() > 1) void'(inflight.pop_back());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
